// File: rtl/frl_pkg.sv
// Shared defaults, widths and types for the free register allocator.
package frl_pkg;

    localparam int FRL_NUM_REG = 64;
    localparam int FRL_AW      = $clog2(FRL_NUM_REG);
    localparam int FRL_CNT_W   = $clog2(FRL_NUM_REG + 1);

    typedef logic [FRL_NUM_REG-1:0] frl_free_vec_t;

    typedef enum logic [1:0] {
        FRL_OP_NORMAL,
        FRL_OP_SAVE,
        FRL_OP_RESTORE
    } frl_ckpt_op_e;

    function automatic int frl_ckpt_w(input int num_ckpt);
        return (num_ckpt > 1) ? $clog2(num_ckpt) : 1;
    endfunction

endpackage

// File: rtl/free_reg_allocator_if.sv
// Allocation / return / checkpoint bus of the free register allocator.
interface free_reg_allocator_if
    import frl_pkg::*;
#(
    parameter int NUM_REG  = FRL_NUM_REG,
    parameter int ALLOC_W  = 2,
    parameter int RET_W    = 2,
    parameter int NUM_CKPT = 4
);

    localparam int AW     = $clog2(NUM_REG);
    localparam int CNT_W  = $clog2(NUM_REG + 1);
    localparam int CKPT_W = frl_ckpt_w(NUM_CKPT);

    logic [ALLOC_W-1:0]    alloc_req;
    logic                  alloc_grant;
    logic [ALLOC_W*AW-1:0] alloc_addr;
    logic                  empty;
    logic [RET_W-1:0]      ret_valid;
    logic [RET_W*AW-1:0]   ret_addr;
    logic                  ckpt_save;
    logic                  ckpt_restore;
    logic [CKPT_W-1:0]     ckpt_save_id;
    logic [CKPT_W-1:0]     ckpt_restore_id;
    logic [CNT_W-1:0]      free_count;
    logic                  err_double_free;

    modport master (
        output alloc_req, ret_valid, ret_addr,
        output ckpt_save, ckpt_restore, ckpt_save_id, ckpt_restore_id,
        input  alloc_grant, alloc_addr, empty, free_count, err_double_free
    );

    modport slave (
        input  alloc_req, ret_valid, ret_addr,
        input  ckpt_save, ckpt_restore, ckpt_save_id, ckpt_restore_id,
        output alloc_grant, alloc_addr, empty, free_count, err_double_free
    );

endinterface

// File: rtl/frl_prio_pick.sv
// Lane selection: each requesting lane takes the lowest free bit not already
// taken by a lower lane (one masked find-first-set stage per lane).
module frl_prio_pick
    import frl_pkg::*;
#(
    parameter int NUM_REG = FRL_NUM_REG,
    parameter int ALLOC_W = 2
) (
    input  logic [NUM_REG-1:0]                  i_free,
    input  logic [ALLOC_W-1:0]                  i_req,
    output logic [ALLOC_W*$clog2(NUM_REG)-1:0]  o_addr,
    output logic [NUM_REG-1:0]                  o_mask
);

    localparam int AW = $clog2(NUM_REG);

    logic [NUM_REG-1:0] w_avail;
    logic               w_hit;
    logic [AW-1:0]      w_idx;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_avail = i_free;
        o_addr  = '0;
        o_mask  = '0;
        w_hit   = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            w_hit = 1'b0;
            w_idx = '0;
            if (i_req[i]) begin
                // Scanning downward leaves the lowest free index as the final hit.
                for (int b = NUM_REG - 1; b >= 0; b--) begin
                    if (w_avail[b]) begin
                        w_hit = 1'b1;
                        w_idx = AW'(b);
                    end
                end
            end
            if (w_hit) begin
                o_addr[i*AW +: AW] = w_idx;
                w_avail[w_idx]     = 1'b0;
                o_mask[w_idx]      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/free_reg_allocator.sv
// Free-list allocator for physical registers with multi-lane alloc/return.
// Checkpoint slots are built only when FRL_CHECKPOINT_EN is defined.
module free_reg_allocator
    import frl_pkg::*;
#(
    parameter int NUM_REG  = FRL_NUM_REG,
    parameter int ALLOC_W  = 2,
    parameter int RET_W    = 2,
    parameter int NUM_CKPT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    free_reg_allocator_if.slave  bus
);

    localparam int AW     = $clog2(NUM_REG);
    localparam int CNT_W  = $clog2(NUM_REG + 1);
    localparam int CKPT_W = frl_ckpt_w(NUM_CKPT);

    typedef logic [NUM_REG-1:0] vec_t;

    vec_t             r_free;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic [ALLOC_W*AW-1:0] w_pick_addr;
    vec_t                  w_pick_mask;
    vec_t                  w_grant_mask;
    vec_t                  w_ret_mask;
    vec_t                  w_live_nxt;
    logic [CNT_W-1:0]      w_req_cnt;
    logic [CNT_W-1:0]      w_grant_cnt;
    logic [CNT_W-1:0]      w_ret_cnt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [AW-1:0]         w_ret_idx;
    logic                  w_dbl;
    logic                  w_grant;
    logic                  w_restore_act;

    frl_prio_pick #(
        .NUM_REG (NUM_REG),
        .ALLOC_W (ALLOC_W)
    ) u_pick (
        .i_free (r_free),
        .i_req  (bus.alloc_req),
        .o_addr (w_pick_addr),
        .o_mask (w_pick_mask)
    );

    // Returns are checked against the live vector and against earlier lanes.
    always_comb begin
        w_req_cnt  = '0;
        w_ret_mask = '0;
        w_ret_cnt  = '0;
        w_dbl      = 1'b0;
        w_ret_idx  = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            w_req_cnt = w_req_cnt + CNT_W'(bus.alloc_req[i]);
        end
        for (int j = 0; j < RET_W; j++) begin
            if (bus.ret_valid[j]) begin
                w_ret_idx = bus.ret_addr[j*AW +: AW];
                if (r_free[w_ret_idx] || w_ret_mask[w_ret_idx]) begin
                    w_dbl = 1'b1;
                end else begin
                    w_ret_mask[w_ret_idx] = 1'b1;
                    w_ret_cnt = w_ret_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign w_grant      = !rst && (|bus.alloc_req) && (w_req_cnt <= r_count) && !w_restore_act;
    assign w_grant_mask = w_grant ? w_pick_mask : '0;
    assign w_grant_cnt  = w_grant ? w_req_cnt : '0;

    assign bus.alloc_grant     = w_grant;
    assign bus.empty           = !rst && (|bus.alloc_req) && !w_grant;
    assign bus.alloc_addr      = w_pick_addr;
    assign bus.free_count      = r_count;
    assign bus.err_double_free = r_err;

`ifdef FRL_CHECKPOINT_EN
    vec_t             r_ckpt [NUM_CKPT];
    frl_ckpt_op_e     w_op;
    vec_t             w_restore_vec;
    logic [CNT_W-1:0] w_restore_cnt;

    always_comb begin
        if (bus.ckpt_restore)   w_op = FRL_OP_RESTORE;
        else if (bus.ckpt_save) w_op = FRL_OP_SAVE;
        else                    w_op = FRL_OP_NORMAL;
        w_restore_vec = r_ckpt[bus.ckpt_restore_id] | w_ret_mask;
        w_restore_cnt = '0;
        for (int b = 0; b < NUM_REG; b++) begin
            w_restore_cnt = w_restore_cnt + CNT_W'(w_restore_vec[b]);
        end
    end

    assign w_restore_act = (w_op == FRL_OP_RESTORE);

    // NOTE: the slots are reset like ordinary flops, not left uninitialised as a
    // memory would be, because a restore straight after reset must yield all-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CKPT; k++) r_ckpt[k] <= '1;
        end else begin
            for (int k = 0; k < NUM_CKPT; k++) begin
                // The saved snapshot reflects this cycle's allocations but not its returns.
                if (w_op == FRL_OP_SAVE && bus.ckpt_save_id == CKPT_W'(k)) begin
                    r_ckpt[k] <= r_free & ~w_grant_mask;
                end else begin
                    r_ckpt[k] <= r_ckpt[k] | w_ret_mask;
                end
            end
        end
    end
`else
    logic [2*CKPT_W+1:0] w_unused_ckpt;

    assign w_unused_ckpt = {bus.ckpt_save, bus.ckpt_restore,
                            bus.ckpt_save_id, bus.ckpt_restore_id};
    assign w_restore_act = 1'b0;
`endif

    always_comb begin
        w_live_nxt  = (r_free & ~w_grant_mask) | w_ret_mask;
        w_count_nxt = r_count + w_ret_cnt - w_grant_cnt;
`ifdef FRL_CHECKPOINT_EN
        if (w_restore_act) begin
            w_live_nxt  = w_restore_vec;
            w_count_nxt = w_restore_cnt;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_free  <= '1;
            r_count <= CNT_W'(NUM_REG);
            r_err   <= 1'b0;
        end else begin
            r_free  <= w_live_nxt;
            r_count <= w_count_nxt;
            r_err   <= r_err | w_dbl;
        end
    end

endmodule

// File: tb/tb_free_reg_allocator.sv
// Directed bench for free_reg_allocator with NUM_REG=8, two lanes, two slots.
module tb_free_reg_allocator;

    localparam int NUM_REG  = 8;
    localparam int ALLOC_W  = 2;
    localparam int RET_W    = 2;
    localparam int NUM_CKPT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    free_reg_allocator_if #(
        .NUM_REG (NUM_REG), .ALLOC_W (ALLOC_W), .RET_W (RET_W), .NUM_CKPT (NUM_CKPT)
    ) bus ();

    free_reg_allocator #(
        .NUM_REG (NUM_REG), .ALLOC_W (ALLOC_W), .RET_W (RET_W), .NUM_CKPT (NUM_CKPT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] req;
        logic [1:0] rv;
        logic [2:0] ra0;
        logic [2:0] ra1;
        logic       grant;
        logic       empty;
        logic [2:0] a0;
        logic [2:0] a1;
        int         cnt;
        logic       err;
    } vec_t;

    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] rv,
                                input logic [2:0] ra0, input logic [2:0] ra1,
                                input logic grant, input logic empty,
                                input logic [2:0] a0, input logic [2:0] a1,
                                input int cnt, input logic err);
        vec_t v;
        v.req = req; v.rv = rv; v.ra0 = ra0; v.ra1 = ra1;
        v.grant = grant; v.empty = empty; v.a0 = a0; v.a1 = a1;
        v.cnt = cnt; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.alloc_req       = '0;
        bus.ret_valid       = '0;
        bus.ret_addr        = '0;
        bus.ckpt_save       = 1'b0;
        bus.ckpt_restore    = 1'b0;
        bus.ckpt_save_id    = '0;
        bus.ckpt_restore_id = '0;
    endtask

    // Called just after a rising edge; leaves the bench just after the next one.
    task automatic apply(input vec_t v, input string tag);
        bus.alloc_req = v.req;
        bus.ret_valid = v.rv;
        bus.ret_addr  = {v.ra1, v.ra0};
        @(negedge clk);
        check($sformatf("%s.grant", tag), 32'(bus.alloc_grant), 32'(v.grant));
        check($sformatf("%s.empty", tag), 32'(bus.empty), 32'(v.empty));
        if (v.grant && v.req[0]) check($sformatf("%s.addr0", tag), 32'(bus.alloc_addr[2:0]), 32'(v.a0));
        if (v.grant && v.req[1]) check($sformatf("%s.addr1", tag), 32'(bus.alloc_addr[5:3]), 32'(v.a1));
        @(posedge clk);
        #1;
        clear_inputs();
        check($sformatf("%s.count", tag), 32'(bus.free_count), 32'(v.cnt));
        check($sformatf("%s.err", tag), 32'(bus.err_double_free), 32'(v.err));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check($sformatf("%s.count", tag), 32'(bus.free_count), 32'(NUM_REG));
        check($sformatf("%s.err", tag), 32'(bus.err_double_free), 32'd0);
        check($sformatf("%s.grant", tag), 32'(bus.alloc_grant), 32'd0);
        check($sformatf("%s.empty", tag), 32'(bus.empty), 32'd0);
    endtask

    vec_t tbl [15];

    initial begin
        // req  rv    ra0   ra1   gnt   emp   a0    a1    cnt err
        tbl[0]  = mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 3'd1, 6, 1'b0);
        tbl[1]  = mk(2'b01, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd2, 3'd0, 5, 1'b0);
        tbl[2]  = mk(2'b10, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 3'd3, 4, 1'b0);
        tbl[3]  = mk(2'b11, 2'b01, 3'd0, 3'd0, 1'b1, 1'b0, 3'd4, 3'd5, 3, 1'b0);
        tbl[4]  = mk(2'b00, 2'b11, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 3'd0, 5, 1'b0);
        tbl[5]  = mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 3'd1, 3, 1'b0);
        tbl[6]  = mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd2, 3'd6, 1, 1'b0);
        tbl[7]  = mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 1'b1, 3'd0, 3'd0, 1, 1'b0);
        tbl[8]  = mk(2'b01, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd7, 3'd0, 0, 1'b0);
        tbl[9]  = mk(2'b01, 2'b10, 3'd0, 3'd3, 1'b0, 1'b1, 3'd0, 3'd0, 1, 1'b0);
        tbl[10] = mk(2'b01, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd3, 3'd0, 0, 1'b0);
        tbl[11] = mk(2'b00, 2'b11, 3'd5, 3'd5, 1'b0, 1'b0, 3'd0, 3'd0, 1, 1'b1);
        tbl[12] = mk(2'b00, 2'b01, 3'd7, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 2, 1'b1);
        tbl[13] = mk(2'b00, 2'b10, 3'd0, 3'd7, 1'b0, 1'b0, 3'd0, 3'd0, 2, 1'b1);
        tbl[14] = mk(2'b01, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd5, 3'd0, 1, 1'b1);

        clear_inputs();
        do_reset("reset0");

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Return of an already-free register sets a sticky error.
        do_reset("reset1");
        apply(mk(2'b00, 2'b01, 3'd7, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 8, 1'b1), "dbl.ret7");
        for (int i = 0; i < 3; i++) begin
            apply(mk(2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 8, 1'b1), $sformatf("dbl.hold%0d", i));
        end
        do_reset("reset2");

        // Asynchronous reset while a grant is pending.
        apply(mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 3'd1, 6, 1'b0), "ar.pre");
        bus.alloc_req = 2'b11;
        #3;
        check("ar.pending_grant", 32'(bus.alloc_grant), 32'd1);
        rst = 1'b1;
        #1;
        check("ar.count", 32'(bus.free_count), 32'd8);
        check("ar.grant", 32'(bus.alloc_grant), 32'd0);
        check("ar.empty", 32'(bus.empty), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        apply(mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 3'd1, 6, 1'b0), "ar.post");

        // Checkpoint save / allocate / return / restore.
        do_reset("reset3");
        apply(mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 3'd1, 6, 1'b0), "ck.a01");
        apply(mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd2, 3'd3, 4, 1'b0), "ck.a23");
        bus.ckpt_save    = 1'b1;
        bus.ckpt_save_id = 1'b1;
        apply(mk(2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 4, 1'b0), "ck.save");
        apply(mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd4, 3'd5, 2, 1'b0), "ck.a45");
        apply(mk(2'b00, 2'b01, 3'd2, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3, 1'b0), "ck.ret2");
        bus.ckpt_restore    = 1'b1;
        bus.ckpt_restore_id = 1'b1;
`ifdef FRL_CHECKPOINT_EN
        apply(mk(2'b01, 2'b00, 3'd0, 3'd0, 1'b0, 1'b1, 3'd0, 3'd0, 5, 1'b0), "ck.restore");
        apply(mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd2, 3'd4, 3, 1'b0), "ck.after");
`else
        apply(mk(2'b01, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd2, 3'd0, 2, 1'b0), "ck.ignored");
        apply(mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd6, 3'd7, 0, 1'b0), "ck.after");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/free_reg_allocator.md
FREE_REG_ALLOCATOR -- requirements
Module: free_reg_allocator

Interface
REQ-001 SHALL have parameter NUM_REG, default 64, physical registers managed; power of 2, at least 4.
REQ-002 SHALL have parameter ALLOC_W, default 2, allocation lanes per cycle.
REQ-003 SHALL have parameter RET_W, default 2, return lanes per cycle.
REQ-004 SHALL have parameter NUM_CKPT, default 4, checkpoint slots; power of 2.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port alloc_req, input, ALLOC_W, per-lane allocation request.
REQ-008 SHALL have port alloc_grant, output, 1, all requested lanes served this cycle.
REQ-009 SHALL have port alloc_addr, output, ALLOC_W*AW (AW=clog2(NUM_REG)), per-lane allocated register.
REQ-010 SHALL have port empty, output, 1, request present but not grantable (stall).
REQ-011 SHALL have port ret_valid, input, RET_W, per-lane return of a committed register.
REQ-012 SHALL have port ret_addr, input, RET_W*AW, per-lane returned register.
REQ-013 SHALL have ports ckpt_save and ckpt_restore, input, 1 each, plus ckpt_save_id and ckpt_restore_id, input, clog2(NUM_CKPT) each.
REQ-014 SHALL have port free_count, output, clog2(NUM_REG+1), registered count of free registers.
REQ-015 SHALL have port err_double_free, output, 1, sticky error flag.

Function
REQ-016 SHALL keep a NUM_REG-bit free vector; bit=1 means free.
REQ-017 SHALL select allocations combinationally: lane 0 takes the lowest-index free bit, each later requesting lane the next-lowest unused; non-requesting lanes consume nothing.
REQ-018 SHALL assert alloc_grant only when popcount(alloc_req) <= free_count and no restore is active (all-or-nothing); otherwise empty=1 and no bit is cleared.
REQ-019 SHALL clear granted bits at the clock edge; alloc_addr on non-requesting lanes is don't-care.
REQ-020 SHALL set returned bits at the clock edge; returned registers are not allocatable before the following cycle (no bypass).
REQ-021 SHALL update free_count each edge by +returns -grants; never wraps.
REQ-022 SHALL, on a return of an already-free register or duplicate addresses within one cycle, set err_double_free (held until reset) and leave the bit at 1 with the count unchanged for that lane.
REQ-023 SHALL, on ckpt_save, store into slot ckpt_save_id the free vector after this cycle's allocations, excluding this cycle's returns.
REQ-024 SHALL apply every return to all checkpoint slots as well as the live vector, so commits between save and restore are not leaked.
REQ-025 SHALL, on ckpt_restore, load the live vector from slot ckpt_restore_id OR this cycle's returns, recompute free_count, and suppress grants that cycle.
REQ-026 SHALL, when save and restore coincide, give restore priority and ignore the save.

Reset
REQ-027 SHALL, on rst, asynchronously set all free-vector and checkpoint bits to 1, free_count=NUM_REG, err_double_free=0; reset mid-allocation discards in-flight grants.

Configuration
REQ-028 SHALL compile checkpoint storage and REQ-023..REQ-026 only when FRL_CHECKPOINT_EN is defined; without it, ckpt ports remain but are ignored and no slot storage is built.

Structure
REQ-029 SHALL place NUM_REG default, AW, count width and a free-vector typedef in shared package frl_pkg.
REQ-030 SHALL implement lane selection in sub-module frl_prio_pick (masked find-first-set, ALLOC_W stages).

Verification (NUM_REG=8, ALLOC_W=2, RET_W=2, NUM_CKPT=2)
REQ-031 SHALL cover: after reset, alloc_req=2'b11 -> alloc_addr lanes 0,1 = 0,1; next cycle free_count=6.
REQ-032 SHALL cover: free_count=1, alloc_req=2'b11 -> alloc_grant=0, empty=1, free_count stays 1.
REQ-033 SHALL cover: return reg 3 with alloc_req=2'b01 while only reg 3 would be free next -> no grant that cycle; grant of 3 on the following cycle.
REQ-034 SHALL cover: save slot 1 with regs 0-3 allocated, allocate 4-5, return reg 2, restore slot 1 -> free vector 8'b1111_0100, free_count=5.
REQ-035 SHALL cover: return reg 7 while already free -> err_double_free=1, remains 1 until rst.
REQ-036 SHALL cover: rst asserted mid-cycle with grant pending -> outputs reset immediately, free_count=8.
